// File: rtl/sipo_shift_ctrl.sv
// ============================================================================
// Module   : sipo_shift_ctrl
// Purpose  : Serialises a parallel word into an external SIPO, captures the
//            SIPO's parallel output and offers it on a valid/ready handshake.
// Options  : SIPO_SHIFT_CTRL_CHECK_EN enables the capture-mismatch checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [WIDTH-1:0]             load_data_i,
    input  logic [WIDTH-1:0]             sipo_output_i,
    input  logic                         out_ready_i,
    output logic                         serial_a_o,
    output logic                         shift_a_o,
    output logic                         busy_o,
    output logic                         out_valid_o,
    output logic [WIDTH-1:0]             out_data_o,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o,
    output logic                         chk_err_o
);

    localparam int CNT_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH-1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_VALID   = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shadow_q;
    logic [WIDTH-1:0]   shadow_d;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               shift_q;
    logic               busy_q;
    logic               valid_q;
    logic               tx_bit_w;

    // The shadow drains toward the transmitted end, so the bit on the wire
    // is always the one sitting at that end of the register.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
            assign tx_bit_w = shadow_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
            assign tx_bit_w = shadow_q[0];
        end
    endgenerate

`ifdef SIPO_SHIFT_CTRL_CHECK_EN
    logic [WIDTH-1:0]   chk_word_q;
    logic [WIDTH-1:0]   exp_word_w;
    logic               chk_err_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_exp_word
            assign exp_word_w[i] = MSB_FIRST ? chk_word_q[WIDTH-1-i] : chk_word_q[i];
        end
    endgenerate

    assign chk_err_o = chk_err_q;
`else
    assign chk_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            out_data_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef SIPO_SHIFT_CTRL_CHECK_EN
            chk_word_q <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        shadow_q  <= load_data_i;
                        bit_cnt_q <= '0;
                        shift_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
`ifdef SIPO_SHIFT_CTRL_CHECK_EN
                        chk_word_q <= load_data_i;
`endif
                    end
                end
                S_SHIFT: begin
                    // Abort takes priority even over the final shift.
                    if (abort_i) begin
                        shift_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        shadow_q  <= shadow_d;
                        bit_cnt_q <= bit_cnt_q + c_ONE;
                        if (bit_cnt_q == c_LAST_CNT) begin
                            shift_q <= 1'b0;
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    out_data_q <= sipo_output_i;
                    valid_q    <= 1'b1;
                    state_q    <= S_VALID;
`ifdef SIPO_SHIFT_CTRL_CHECK_EN
                    chk_err_q  <= (sipo_output_i != exp_word_w);
`endif
                end
                S_VALID: begin
                    if (out_ready_i) begin
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= S_IDLE;
`ifdef SIPO_SHIFT_CTRL_CHECK_EN
                        chk_err_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign shift_a_o   = shift_q;
    assign serial_a_o  = shift_q & tx_bit_w;
    assign busy_o      = busy_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = out_data_q;
    assign bit_cnt_o   = bit_cnt_q;

endmodule

`default_nettype wire
